// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg
//   Shared definitions for the register-bus arbiter: FSM state encoding,
//   requester identifiers, parameter defaults and the round-robin pick.
package reg_bus_pkg;

    localparam int          DEF_REG_WIDTH  = 8;
    localparam int          DEF_ADDR_WIDTH = 1;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h3000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_WB  = 1'b0,
        REQ_SPI = 1'b1
    } requester_e;

    // On a tie the requester that was not served last wins; otherwise the
    // only requester present wins. Only meaningful when a request exists.
    function automatic requester_e rr_pick(input logic       wb_req,
                                           input logic       spi_req,
                                           input requester_e last_served);
        requester_e pick;
        if (wb_req && spi_req) begin
            if (last_served == REQ_SPI) pick = REQ_WB;
            else                        pick = REQ_SPI;
        end else if (wb_req) begin
            pick = REQ_WB;
        end else begin
            pick = REQ_SPI;
        end
        return pick;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if
//   Bundles the three buses around the arbiter.
//   Wishbone slave : wbs_stb_i/cyc_i/we_i/adr_i/dat_i in, wbs_ack_o/dat_o out
//   SPI side       : spi_req_i/we_i/addr_i/wdata_i in, spi_gnt_o/done_o/rdata_o out
//   Register bus   : reg_clk/reg_dir/reg_addr/reg_bus_o/reg_bus_oe out, reg_bus_i in
//   Modport slave is the arbiter side, master is the environment side.
interface reg_bus_arbiter_if
    import reg_bus_pkg::*;
#(
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  wbs_stb_i;
    logic                  wbs_cyc_i;
    logic                  wbs_we_i;
    logic [31:0]           wbs_adr_i;
    logic [31:0]           wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;

    logic                  spi_req_i;
    logic                  spi_we_i;
    logic [ADDR_WIDTH:0]   spi_addr_i;
    logic [REG_WIDTH-1:0]  spi_wdata_i;
    logic                  spi_gnt_o;
    logic                  spi_done_o;
    logic [REG_WIDTH-1:0]  spi_rdata_o;

    logic                  reg_clk;
    logic                  reg_dir;
    logic [ADDR_WIDTH:0]   reg_addr;
    logic                  reg_bus_o;
    logic                  reg_bus_oe;
    logic                  reg_bus_i;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  spi_req_i, spi_we_i, spi_addr_i, spi_wdata_i,
        output spi_gnt_o, spi_done_o, spi_rdata_o,
        output reg_clk, reg_dir, reg_addr, reg_bus_o, reg_bus_oe,
        input  reg_bus_i
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output spi_req_i, spi_we_i, spi_addr_i, spi_wdata_i,
        input  spi_gnt_o, spi_done_o, spi_rdata_o,
        input  reg_clk, reg_dir, reg_addr, reg_bus_o, reg_bus_oe,
        output reg_bus_i
    );

endinterface

// File: rtl/reg_bus_shifter.sv
// reg_bus_shifter
//   Serialises one register transfer: shift register, bit-phase counter and
//   reg_clk generation. Each bit takes two cycles (reg_clk low, then high),
//   MSB first. Read data is captured on the edge that ends each high cycle.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     load_i          load load_data_i and clear the counter (idle only)
//     go_i            start shifting on the next cycle
//     dir_i           1 = write (drive ser_o), 0 = read (capture ser_i)
//     ser_i           serial read data from the register bus
//     reg_clk_o       registered strobe
//     ser_o, ser_oe_o registered serial write data and its enable
//     last_o          high in the final shift cycle
//     data_next_o     next shift-register value (read result on last_o)
module reg_bus_shifter
    import reg_bus_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [REG_WIDTH-1:0] load_data_i,
    input  logic                 go_i,
    input  logic                 dir_i,
    input  logic                 ser_i,
    output logic                 reg_clk_o,
    output logic                 ser_o,
    output logic                 ser_oe_o,
    output logic                 last_o,
    output logic [REG_WIDTH-1:0] data_next_o
);
    localparam int                CNT_W    = $clog2(2 * REG_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(2 * REG_WIDTH - 1);

    logic [REG_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 active_q, active_d;
    logic                 reg_clk_q, reg_clk_d;
    logic                 ser_q, ser_d;
    logic                 ser_oe_q, ser_oe_d;

    assign last_o = active_q && (cnt_q == CNT_LAST);

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            shift_d  = load_data_i;
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (go_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            // Odd count = reg_clk high; its closing edge moves to the next bit.
            if (cnt_q[0]) begin
                shift_d = {shift_q[REG_WIDTH-2:0], dir_i ? 1'b0 : ser_i};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (last_o) active_d = 1'b0;
        end
        // Outputs are registered copies of what the next cycle must show.
        reg_clk_d = active_d & cnt_d[0];
        ser_oe_d  = active_d & dir_i;
        ser_d     = active_d & dir_i & shift_d[REG_WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
            reg_clk_q <= 1'b0;
            ser_q     <= 1'b0;
            ser_oe_q  <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            reg_clk_q <= reg_clk_d;
            ser_q     <= ser_d;
            ser_oe_q  <= ser_oe_d;
        end
    end

    assign reg_clk_o   = reg_clk_q;
    assign ser_o       = ser_q;
    assign ser_oe_o    = ser_oe_q;
    assign data_next_o = shift_d;

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Shares one serial register bus between a Wishbone slave window and an
//   SPI-side requester. Round-robin arbitration in IDLE, then
//   GRANT -> SHIFT (2*REG_WIDTH cycles) -> DONE, where ack/done pulses.
//   Ports:
//     wb_clk_i  clock;  wb_rst_i  asynchronous active-high reset
//     bus       reg_bus_arbiter_if.slave (Wishbone, SPI and register bus)
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int          REG_WIDTH  = DEF_REG_WIDTH,
    parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    reg_bus_arbiter_if.slave bus
);
    localparam int AW = ADDR_WIDTH + 1;

    state_e               state_q, state_d;
    requester_e           last_q, last_d;
    requester_e           win_q, win_d;
    logic                 abort_q, abort_d;
    logic [AW-1:0]        reg_addr_q, reg_addr_d;
    logic                 reg_dir_q, reg_dir_d;
    logic                 wbs_ack_q, wbs_ack_d;
    logic [31:0]          wbs_dat_q, wbs_dat_d;
    logic                 spi_gnt_q, spi_gnt_d;
    logic                 spi_done_q, spi_done_d;
    logic [REG_WIDTH-1:0] spi_rdata_q, spi_rdata_d;

    logic                 wb_live, wb_req, any_req;
    requester_e           pick;
    logic [REG_WIDTH-1:0] load_data;
    logic                 load_dir;
    logic [AW-1:0]        load_addr;
    logic                 sh_load, sh_go, sh_last;
    logic                 sh_reg_clk, sh_ser, sh_ser_oe;
    logic [REG_WIDTH-1:0] sh_data_next;
    logic                 unused_bits;

    // Address and data bits outside the window decode are deliberately ignored.
    assign unused_bits = ^{bus.wbs_adr_i, bus.wbs_dat_i};

    always_comb begin
        wb_live   = bus.wbs_stb_i & bus.wbs_cyc_i;
        wb_req    = wb_live && (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        any_req   = wb_req | bus.spi_req_i;
        pick      = rr_pick(wb_req, bus.spi_req_i, last_q);
        load_data = (pick == REQ_WB) ? bus.wbs_dat_i[REG_WIDTH-1:0] : bus.spi_wdata_i;
        load_dir  = (pick == REQ_WB) ? bus.wbs_we_i : bus.spi_we_i;
        load_addr = (pick == REQ_WB) ? bus.wbs_adr_i[ADDR_WIDTH+2:2] : bus.spi_addr_i;
        sh_load   = (state_q == ST_IDLE) && any_req;
        sh_go     = (state_q == ST_GRANT);
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        abort_d     = abort_q;
        reg_addr_d  = reg_addr_q;
        reg_dir_d   = reg_dir_q;
        spi_gnt_d   = spi_gnt_q;
        spi_rdata_d = spi_rdata_q;
        wbs_ack_d   = 1'b0;
        wbs_dat_d   = '0;
        spi_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_GRANT;
                    win_d      = pick;
                    last_d     = pick;
                    reg_addr_d = load_addr;
                    reg_dir_d  = load_dir;
                    abort_d    = 1'b0;
                    spi_gnt_d  = (pick == REQ_SPI);
                end
            end
            ST_GRANT, ST_SHIFT: begin
                if (state_q == ST_GRANT) state_d = ST_SHIFT;
                // A Wishbone master that walks away still gets its bus
                // transfer finished, but must never see a stray ack.
                if (win_q == REQ_WB && !wb_live) abort_d = 1'b1;
                if (state_q == ST_SHIFT && sh_last) begin
                    state_d = ST_DONE;
                    if (win_q == REQ_WB) begin
                        if (!abort_q && wb_live) begin
                            wbs_ack_d = 1'b1;
                            if (!reg_dir_q)
                                wbs_dat_d = {{(32-REG_WIDTH){1'b0}}, sh_data_next};
                        end
                    end else begin
                        spi_done_d = 1'b1;
                        if (!reg_dir_q) spi_rdata_d = sh_data_next;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                spi_gnt_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            last_q      <= REQ_SPI;
            win_q       <= REQ_WB;
            abort_q     <= 1'b0;
            reg_addr_q  <= '0;
            reg_dir_q   <= 1'b0;
            wbs_ack_q   <= 1'b0;
            wbs_dat_q   <= '0;
            spi_gnt_q   <= 1'b0;
            spi_done_q  <= 1'b0;
            spi_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            abort_q     <= abort_d;
            reg_addr_q  <= reg_addr_d;
            reg_dir_q   <= reg_dir_d;
            wbs_ack_q   <= wbs_ack_d;
            wbs_dat_q   <= wbs_dat_d;
            spi_gnt_q   <= spi_gnt_d;
            spi_done_q  <= spi_done_d;
            spi_rdata_q <= spi_rdata_d;
        end
    end

    reg_bus_shifter #(
        .REG_WIDTH (REG_WIDTH)
    ) u_shifter (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .load_i      (sh_load),
        .load_data_i (load_data),
        .go_i        (sh_go),
        .dir_i       (reg_dir_q),
        .ser_i       (bus.reg_bus_i),
        .reg_clk_o   (sh_reg_clk),
        .ser_o       (sh_ser),
        .ser_oe_o    (sh_ser_oe),
        .last_o      (sh_last),
        .data_next_o (sh_data_next)
    );

    assign bus.wbs_ack_o   = wbs_ack_q;
    assign bus.wbs_dat_o   = wbs_dat_q;
    assign bus.spi_gnt_o   = spi_gnt_q;
    assign bus.spi_done_o  = spi_done_q;
    assign bus.spi_rdata_o = spi_rdata_q;
    assign bus.reg_clk     = sh_reg_clk;
    assign bus.reg_dir     = reg_dir_q;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_bus_o   = sh_ser;
    assign bus.reg_bus_oe  = sh_ser_oe;

endmodule
